// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI mode-0 slave (SCLK idles low, data sampled on SCLK rise, shifted on SCLK
// fall), MSB first, WIDTH-bit words. All SPI pins are oversampled in the clk
// domain through SYNC_STAGES-deep synchronizers. Each SCLK phase must last at
// least SYNC_STAGES+2 clk cycles.
//
// A transmit holding register decouples the host from the frame timing. The
// shift register is loaded from it at the start of a frame and at each word
// boundary, so several words can be sent back-to-back under one SS.
//
// Handshake: wrReady is high while the holding register is empty. A wrLoad
// pulse with wrReady high fills it, and wrReady falls on the next cycle. A
// wrLoad pulse with wrReady low overwrites the pending word. There is no
// backpressure on the receive side: rdValid is a one-cycle pulse that marks a
// new rdData word, and the host must take it that cycle or lose it.
//
// Ports
//   clk        system clock, rising-edge
//   resn       asynchronous active-low reset
//   SCLK       SPI clock from master
//   SS         slave select, active-low
//   MOSI       serial data from master
//   MISO       serial data to master (0 while idle)
//   wrData     word for the holding register
//   wrLoad     one-cycle strobe, writes wrData into the holding register
//   wrReady    holding register empty
//   rdData     last complete received word
//   rdValid    one-cycle pulse when rdData updates
//   abort      one-cycle pulse when SS rises mid-word
//   dbg_state  current FSM state (0 IDLE, 1 LOAD, 2 SHIFT)
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] wrData,
    input  logic             wrLoad,
    output logic             wrReady,
    output logic [WIDTH-1:0] rdData,
    output logic             rdValid,
    output logic             abort,
    output logic [1:0]       dbg_state
);

    // A single-flop synchronizer is not acceptable, so depths below 2 are
    // raised to 2.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic              sclk_prev, ss_prev;
    logic              sclk_s, ss_s, mosi_s;
    logic              ss_fall, ss_rise;
    logic              sclk_rise, sclk_fall;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[STAGES-2:0], SS};
            mosi_sync <= {mosi_sync[STAGES-2:0], MOSI};
            sclk_prev <= sclk_sync[STAGES-1];
            ss_prev   <= ss_sync[STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[STAGES-1];
    assign ss_s   = ss_sync[STAGES-1];
    assign mosi_s = mosi_sync[STAGES-1];

    assign ss_fall = ~ss_s & ss_prev;
    assign ss_rise = ss_s & ~ss_prev;

    // SCLK activity is only meaningful while the slave is selected. Gating on
    // ss_s also keeps a word completion and an abort from ever landing in the
    // same cycle, since an abort needs ss_s high.
    assign sclk_rise = ~ss_s & sclk_s & ~sclk_prev;
    assign sclk_fall = ~ss_s & ~sclk_s & sclk_prev;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   state_d = SHIFT;
            default: state_d = IDLE;
        endcase
        // A deselected slave always returns to IDLE, whatever it was doing.
        if (ss_s) state_d = IDLE;
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [CNT_W-1:0] bit_cnt;
    logic             reload_pend;
    logic             in_shift;
    logic             word_done;
    logic             tx_load;
    logic [WIDTH-1:0] load_word;

    assign in_shift  = (state_q == SHIFT);
    assign word_done = in_shift && sclk_rise && (bit_cnt == CNT_W'(WIDTH - 1));

    // At a word boundary the next falling edge reloads instead of shifting.
    assign tx_load   = (state_q == LOAD) || (in_shift && sclk_fall && reload_pend);

    // A wrLoad that coincides with a tx load goes straight into the shift
    // register. With no new write, the old holding value is sent again.
    assign load_word = wrLoad ? wrData : hold_q;

    // rx_shift keeps only the WIDTH-1 most recent bits. The incoming bit
    // completes the word.
    assign rx_next   = {rx_shift, mosi_s};

    // ------------------------------------------------------------------
    // Transmit holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (tx_load) begin
            // hold_q keeps its value so an underrun can repeat it.
            hold_full <= 1'b0;
        end else if (wrLoad) begin
            hold_q    <= wrData;
            hold_full <= 1'b1;
        end
    end

    assign wrReady = ~hold_full;

    // ------------------------------------------------------------------
    // Transmit shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            tx_shift <= '0;
        end else if (tx_load) begin
            tx_shift <= load_word;
        end else if (in_shift && sclk_fall) begin
            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
    end

    // During LOAD the shift register is not yet written, so the word about to
    // be loaded supplies the first bit.
    always_comb begin
        MISO = 1'b0;
        case (state_q)
            LOAD:    MISO = load_word[WIDTH-1];
            SHIFT:   MISO = tx_shift[WIDTH-1];
            default: MISO = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive path, bit counter and word-boundary bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else if (!in_shift) begin
            // Outside SHIFT, any partial word is dropped.
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else begin
            if (sclk_rise) begin
                rx_shift <= rx_next[WIDTH-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done) begin
                reload_pend <= 1'b1;
            end else if (sclk_fall) begin
                reload_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Host-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            rdData  <= '0;
            rdValid <= 1'b0;
            abort   <= 1'b0;
        end else begin
            rdValid <= word_done;
            if (word_done) begin
                rdData <= rx_next;
            end
            // SS rising with the counter at 0 is a clean end of frame.
            abort <= in_shift && ss_rise && (bit_cnt != '0);
        end
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 16: frame word length in bits, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on SCLK, SS and MOSI, minimum 2.
REQ-003 clk  input  1  system clock; all state is sampled on its rising edge.
REQ-004 resn  input  1  reset; asynchronous, active-low.
REQ-005 SCLK  input  1  SPI clock from the master; mode 0 (idle low, sample on rise, shift on fall).
REQ-006 SS  input  1  slave select from the master, active-low.
REQ-007 MOSI  input  1  serial data from the master.
REQ-008 MISO  output  1  serial data to the master.
REQ-009 wrData  input  WIDTH  word to transmit in the next frame.
REQ-010 wrLoad  input  1  single-cycle strobe that writes wrData into the transmit holding register.
REQ-011 wrReady  output  1  high while the holding register is empty.
REQ-012 rdData  output  WIDTH  last complete received word.
REQ-013 rdValid  output  1  single-cycle pulse when rdData updates.
REQ-014 abort  output  1  single-cycle pulse when SS rises mid-word.

Function
REQ-015 SCLK, SS and MOSI shall each pass through SYNC_STAGES flops; edges shall be detected from the last two synchronized samples.
REQ-016 Correct operation requires each SCLK high and low phase to last at least SYNC_STAGES+2 clk cycles.
REQ-017 FSM states: IDLE, LOAD, SHIFT.
- IDLE to LOAD on synchronized SS falling.
- LOAD to SHIFT after one cycle.
- SHIFT to IDLE on synchronized SS rising.
- Any state to IDLE while SS is synchronized high.
REQ-018 LOAD behaviour:
- Copy the holding register into the tx shift register, then mark the holding register empty.
- Clear the bit counter.
- Drive MISO with the tx shift register MSB.
REQ-019 SHIFT, synchronized SCLK rising: shift the synchronized MOSI into the rx shift register LSB and increment the bit counter.
REQ-020 SHIFT, synchronized SCLK falling: shift the tx shift register left by one; MISO shall present the new MSB on the following clk cycle.
REQ-021 When the counter reaches WIDTH on a rising edge:
- Copy the rx shift register into rdData and pulse rdValid the next cycle.
- Wrap the counter to 0.
- Reload the tx shift register from the holding register on the next falling edge instead of shifting (back-to-back words under one SS).
REQ-022 Holding register empty at a tx load:
- The previous holding value is retransmitted.
- wrReady stays high.
REQ-023 wrLoad behaviour:
- wrLoad with wrReady high writes the holding register and drops wrReady the next cycle.
- wrLoad with wrReady low overwrites the holding register.
REQ-024 wrLoad in the same cycle as a tx load: wrData goes straight into the tx shift register and the holding register stays empty.
REQ-025 SS rising in SHIFT with the counter nonzero:
- Pulse abort.
- Leave rdData unchanged and do not pulse rdValid.
- Discard the partial word.
REQ-026 SS rising with the counter at 0 shall not pulse abort.
REQ-027 MISO shall be 0 whenever the FSM is IDLE.
REQ-028 SCLK edges while SS is synchronized high shall be ignored.
REQ-029 rdValid and abort shall never be high in the same cycle.

Reset
REQ-030 While resn is low, all outputs and internal registers shall assume their reset values with no clk edge required:
- FSM IDLE.
- MISO=0, rdData=0, rdValid=0, abort=0.
- wrReady=1; holding, shift and synchronizer registers all 0.
REQ-031 Reset asserted mid-frame shall discard the frame with no rdValid or abort pulse; after release the block waits for a fresh SS falling edge.

Verification
REQ-032 Single frame:
- Stimulus: wrLoad 0xA55A, then master sends 0x1234 at an 8-clk SCLK half-period.
- Response: MISO bit stream 0xA55A; rdData=0x1234; one rdValid pulse; wrReady returns to 1.
REQ-033 Back-to-back words:
- Stimulus: holding 0xBEEF loaded before, and 0x0F0F loaded during, word 1; 32 SCLK cycles under one SS carrying 0x0001 then 0x8000.
- Response: MISO 0xBEEF then 0x0F0F; two rdValid pulses with rdData 0x0001 then 0x8000.
- Response: abort stays 0.
REQ-034 Abort: SS rises after 7 bits -> one abort pulse, no rdValid, rdData unchanged; the next full frame is received correctly.
REQ-035 Underrun: two frames with only one wrLoad (0x00FF) -> both frames transmit 0x00FF; wrReady is 1 after the first LOAD.
REQ-036 Simultaneous load: wrLoad 0x5555 in the LOAD cycle -> 0x5555 is transmitted and wrReady remains 1.
REQ-037 Async reset: resn pulled low mid-frame between clk edges -> outputs reach their reset values immediately; no pulses on release; the next frame works.
